rom_loader: RTL and testbench

- Write side of the core's ROM download path.
- Consumes the MiSTer ioctl download byte stream for one download index.
- Splits the stream into up to four ROM regions by address.
- Drives each region ROM's load port (address, data, write strobe) with registered outputs.
- Reports load completion, byte count and out-of-range errors, so CPU reset can be held until ROMs are valid.

---
 rtl/rom_loader_pkg.sv | 13 +
 rtl/rom_loader_if.sv | 21 ++
 rtl/rom_region_decode.sv | 52 +++++
 rtl/rom_loader.sv | 138 +++++++++++++
 tb/tb_rom_loader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM download path (rom_loader and its region decoder).
package rom_loader_pkg;

  localparam int NUM_REGIONS = 4;
  localparam int IOCTL_AW    = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// MiSTer ioctl download stream as seen by a loader: master is the HPS side, slave is the loader.
interface rom_loader_if;
  import rom_loader_pkg::*;

  // ioctl_wr is a one-cycle valid strobe qualified by ioctl_download; there is no ready/backpressure,
  // so a slave must take one byte every cycle ioctl_wr is high, including back-to-back cycles.
  logic                ioctl_download;
  logic [7:0]          ioctl_index;
  logic                ioctl_wr;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_dout;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );

  modport slave (
    input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );

endinterface

// File: rtl/rom_region_decode.sv
// Combinational map from a download address to a one-hot ROM region, in-range flag and region offset.
module rom_region_decode
  import rom_loader_pkg::*;
#(
  parameter int                  ADDR_W   = 16,
  parameter logic [IOCTL_AW-1:0] R0_BASE  = 25'h00000,
  parameter logic [IOCTL_AW-1:0] R1_BASE  = 25'h10000,
  parameter logic [IOCTL_AW-1:0] R2_BASE  = 25'h20000,
  parameter logic [IOCTL_AW-1:0] R3_BASE  = 25'h30000,
  parameter logic [IOCTL_AW-1:0] END_ADDR = 25'h40000
) (
  input  logic [IOCTL_AW-1:0]    addr,
  output logic [NUM_REGIONS-1:0] region_oh,
  output logic                   in_range,
  output logic [ADDR_W-1:0]      offset
);

  localparam logic [IOCTL_AW-1:0] BOUND [NUM_REGIONS+1] =
    '{R0_BASE, R1_BASE, R2_BASE, R3_BASE, END_ADDR};

  if (ADDR_W > IOCTL_AW) begin : g_bad_addr_w
    $error("rom_region_decode: ADDR_W wider than the ioctl address");
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_chk
    if ((BOUND[g+1] < BOUND[g]) ||
        ({1'b0, BOUND[g+1] - BOUND[g]} > (26'd1 << ADDR_W))) begin : g_bad
      $error("rom_region_decode: region %0d unordered or larger than 2^ADDR_W", g);
    end
  end

  logic [NUM_REGIONS:0] ge;

  // {a,1} > {b,0} is a >= b without a constant-zero comparison when a base is 0.
  always_comb begin
    ge        = '0;
    region_oh = '0;
    offset    = '0;
    for (int k = 0; k <= NUM_REGIONS; k++) begin
      ge[k] = ({addr, 1'b1} > {BOUND[k], 1'b0});
    end
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (ge[i] && !ge[i+1]) begin
        region_oh[i] = 1'b1;
        offset       = addr[ADDR_W-1:0] - BOUND[i][ADDR_W-1:0];
      end
    end
  end

  assign in_range = |region_oh;

endmodule

// File: rtl/rom_loader.sv
// Write side of the ROM download path: splits one ioctl download index into four region load ports.
// Optional ROM_LOADER_CSUM_EN adds a running byte sum (csum/csum_ok) that also gates rom_ready.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int                  ADDR_W      = 16,
  parameter logic [7:0]          ROM_INDEX   = 8'd0,
  parameter logic [IOCTL_AW-1:0] R0_BASE     = 25'h00000,
  parameter logic [IOCTL_AW-1:0] R1_BASE     = 25'h10000,
  parameter logic [IOCTL_AW-1:0] R2_BASE     = 25'h20000,
  parameter logic [IOCTL_AW-1:0] R3_BASE     = 25'h30000,
`ifdef ROM_LOADER_CSUM_EN
  parameter logic [15:0]         EXPECT_CSUM = 16'h0000,
`endif
  parameter logic [IOCTL_AW-1:0] END_ADDR    = 25'h40000
) (
  input  logic                   clk,
  input  logic                   reset,
  rom_loader_if.slave            io,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic [NUM_REGIONS-1:0] rom_we,
  output logic                   rom_ready,
  output logic                   load_done,
  output logic                   load_err,
  output logic [IOCTL_AW-1:0]    bytes_loaded,
`ifdef ROM_LOADER_CSUM_EN
  output logic [15:0]            csum,
  output logic                   csum_ok,
`endif
  output state_t                 dbg_state
);

  localparam logic [IOCTL_AW-1:0] CNT_MAX = '1;

  state_t                   state, state_nxt;
  logic                     blocked;
  logic                     match, accept, entry;
  logic [NUM_REGIONS-1:0]   region_oh;
  logic                     in_range;
  logic [ADDR_W-1:0]        offset;
  logic [IOCTL_AW-1:0]      cnt_base;

  rom_region_decode #(
    .ADDR_W   (ADDR_W),
    .R0_BASE  (R0_BASE),
    .R1_BASE  (R1_BASE),
    .R2_BASE  (R2_BASE),
    .R3_BASE  (R3_BASE),
    .END_ADDR (END_ADDR)
  ) u_decode (
    .addr      (io.ioctl_addr),
    .region_oh (region_oh),
    .in_range  (in_range),
    .offset    (offset)
  );

  // blocked discards the tail of a download that was cut by reset until ioctl_download drops.
  assign match     = io.ioctl_download & (io.ioctl_index == ROM_INDEX) & ~blocked;
  assign accept    = match & io.ioctl_wr & (state != FINISH);
  assign entry     = (state == IDLE) & match;
  assign cnt_base  = entry ? '0 : bytes_loaded;
  assign load_done = (state == FINISH);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (match)  state_nxt = LOAD;
      LOAD:    if (!match) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The entry cycle both clears the status and may carry a byte, so counters start from cnt_base.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr     <= '0;
      rom_data     <= '0;
      rom_we       <= '0;
      rom_ready    <= 1'b0;
      load_err     <= 1'b0;
      bytes_loaded <= '0;
      blocked      <= io.ioctl_download;
    end else begin
      rom_we <= '0;
      if (!io.ioctl_download) blocked <= 1'b0;
      if (entry) begin
        load_err     <= 1'b0;
        rom_ready    <= 1'b0;
        bytes_loaded <= '0;
      end
      if (accept) begin
        if (in_range) begin
          rom_we       <= region_oh;
          rom_addr     <= offset;
          rom_data     <= io.ioctl_dout;
          bytes_loaded <= (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end
      if (state == FINISH) begin
`ifdef ROM_LOADER_CSUM_EN
        rom_ready <= !load_err && (csum == EXPECT_CSUM);
`else
        rom_ready <= !load_err;
`endif
      end
    end
  end

`ifdef ROM_LOADER_CSUM_EN
  logic [15:0] csum_base;
  assign csum_base = entry ? 16'h0000 : csum;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum    <= '0;
      csum_ok <= 1'b0;
    end else begin
      if (entry) begin
        csum    <= '0;
        csum_ok <= 1'b0;
      end
      if (accept && in_range) csum <= csum_base + {8'h00, io.ioctl_dout};
      if (state == FINISH)    csum_ok <= (csum == EXPECT_CSUM);
    end
  end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Randomised scoreboard bench for rom_loader: region writes, status after each download, reset abort.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int ADDR_W = 16;
  localparam int W      = 32 + 4 + ADDR_W + 8;
  localparam int unsigned BOUNDS [5] = '{32'h00000, 32'h10000, 32'h20000, 32'h30000, 32'h40000};

  logic                   clk = 1'b0;
  logic                   reset;
  logic [ADDR_W-1:0]      rom_addr;
  logic [7:0]             rom_data;
  logic [NUM_REGIONS-1:0] rom_we;
  logic                   rom_ready, load_done, load_err;
  logic [IOCTL_AW-1:0]    bytes_loaded;
  state_t                 dbg_state;
`ifdef ROM_LOADER_CSUM_EN
  logic [15:0]            csum;
  logic                   csum_ok;
`endif

  rom_loader_if io ();

  rom_loader #(
    .ADDR_W (ADDR_W)
`ifdef ROM_LOADER_CSUM_EN
    , .EXPECT_CSUM (16'h0103)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io           (io),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .rom_we       (rom_we),
    .rom_ready    (rom_ready),
    .load_done    (load_done),
    .load_err     (load_err),
    .bytes_loaded (bytes_loaded),
`ifdef ROM_LOADER_CSUM_EN
    .csum         (csum),
    .csum_ok      (csum_ok),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  int           done_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e, got_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
    if (rom_we != '0) begin
      n_checks++;
      got_e = {32'(cyc), rom_we, rom_addr, rom_data};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: cyc=%0d we=%b addr=%h data=%h", cyc, rom_we, rom_addr, rom_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (got_e !== exp_e) begin
          n_fail++;
          $display("FAIL rom_write: got cyc=%0d we=%b addr=%h data=%h expected cyc=%0d we=%b addr=%h data=%h",
                   got_e[W-1 -: 32], got_e[27:24], got_e[23:8], got_e[7:0],
                   exp_e[W-1 -: 32], exp_e[27:24], exp_e[23:8], exp_e[7:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit          m_active, m_blocked, m_err, m_ready;
  int          m_bytes, m_done;
  logic [15:0] m_csum;

  function automatic int region_of(input int unsigned a);
    for (int i = 0; i < 4; i++)
      if (a >= BOUNDS[i] && a < BOUNDS[i+1]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_blocked = (io.ioctl_download == 1'b1);
    m_active  = 0;
    m_err     = 0;
    m_ready   = 0;
    m_bytes   = 0;
    m_csum    = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dl_begin(input int idx);
    io.ioctl_download = 1'b1;
    io.ioctl_index    = 8'(idx);
    m_active          = (idx == 0) && !m_blocked;
    if (m_active) begin
      m_bytes = 0;
      m_err   = 0;
      m_ready = 0;
      m_csum  = '0;
    end
  endtask

  task automatic send(input int unsigned a, input logic [7:0] d);
    int          r;
    int unsigned off;
    logic [3:0]  oh;
    io.ioctl_wr   = 1'b1;
    io.ioctl_addr = a[24:0];
    io.ioctl_dout = d;
    if (m_active && !reset) begin
      r = region_of(a);
      if (r >= 0) begin
        off = a - BOUNDS[r];
        oh  = 4'b0001 << r;
        exp_q.push_back({32'(cyc + 1), oh, off[15:0], d});
        m_bytes++;
        m_csum = m_csum + 16'(d);
      end else begin
        m_err = 1;
      end
    end
    @(posedge clk);
    #1;
    io.ioctl_wr = 1'b0;
  endtask

  task automatic dl_end_check(input string tag);
    io.ioctl_download = 1'b0;
    io.ioctl_wr       = 1'b0;
    idle(4);
    if (m_active) begin
      m_done++;
`ifdef ROM_LOADER_CSUM_EN
      m_ready = !m_err && (m_csum == 16'h0103);
`else
      m_ready = !m_err;
`endif
    end
    m_active  = 0;
    m_blocked = 0;
    check({tag, ".load_done_count"}, 32'(done_cnt), 32'(m_done));
    check({tag, ".rom_ready"}, 32'(rom_ready), 32'(m_ready));
    check({tag, ".bytes_loaded"}, 32'(bytes_loaded), 32'(m_bytes));
    check({tag, ".load_err"}, 32'(load_err), 32'(m_err));
`ifdef ROM_LOADER_CSUM_EN
    check({tag, ".csum"}, 32'(csum), 32'(m_csum));
`endif
  endtask

  task automatic send_rand_in_range(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send($urandom_range(32'h3FFFF, 0), 8'($urandom));
      idle($urandom_range(max_gap, 0));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] csum_bytes [5];

  initial begin
    reset             = 1'b1;
    io.ioctl_download = 1'b0;
    io.ioctl_index    = 8'd0;
    io.ioctl_wr       = 1'b0;
    io.ioctl_addr     = '0;
    io.ioctl_dout     = '0;
    m_done            = 0;
    idle(3);
    model_reset();
    check("reset.rom_we", 32'(rom_we), 32'd0);
    check("reset.rom_ready", 32'(rom_ready), 32'd0);
    check("reset.load_done", 32'(load_done), 32'd0);
    check("reset.load_err", 32'(load_err), 32'd0);
    check("reset.bytes_loaded", 32'(bytes_loaded), 32'd0);
    check("reset.state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    idle(2);

    // Two bytes in two regions; the first arrives on the download's first cycle.
    dl_begin(0);
    send(32'h00000, 8'hA5);
    idle(2);
    send(32'h10003, 8'h3C);
    idle(1);
    dl_end_check("basic");

    // Back-to-back stream across every region boundary; restart drops rom_ready at once.
    dl_begin(0);
    send(32'h0FFF0, 8'($urandom));
    check("restart.rom_ready_drop", 32'(rom_ready), 32'd0);
    for (int b = 1; b <= 3; b++)
      for (int unsigned a = BOUNDS[b] - 8; a < BOUNDS[b] + 8; a++) send(a, 8'($urandom));
    for (int unsigned a = 32'h3FFF8; a < 32'h40000; a++) send(a, 8'($urandom));
    send_rand_in_range(40, 0);
    dl_end_check("boundaries");

    // Another index must leave everything untouched.
    dl_begin(1);
    send_rand_in_range(20, 1);
    dl_end_check("other_index");

    // Out-of-range bytes set the sticky error and suppress the write.
    dl_begin(0);
    send_rand_in_range(5, 1);
    send(32'h40000, 8'h77);
    send($urandom_range(32'h1FFFFFF, 32'h40001), 8'($urandom));
    send_rand_in_range(5, 0);
    dl_end_check("out_of_range");

    // Byte-sum sequence, then the same sequence with one byte corrupted.
    csum_bytes = '{8'h01, 8'h02, 8'h00, 8'h01, 8'hFF};
    for (int pass = 0; pass < 2; pass++) begin
      dl_begin(0);
      for (int i = 0; i < 5; i++)
        send($urandom_range(32'h3FFFF, 0), (pass == 1 && i == 4) ? 8'hFE : csum_bytes[i]);
      dl_end_check(pass == 0 ? "csum_good" : "csum_bad");
    end

    // Reset after 10 bytes while the stream continues: the tail must be ignored.
    dl_begin(0);
    send_rand_in_range(10, 0);
    reset = 1'b1;
    model_reset();
    send_rand_in_range(3, 0);
    reset = 1'b0;
    send_rand_in_range(10, 1);
    dl_end_check("reset_abort");

    dl_begin(0);
    send_rand_in_range(5, 1);
    dl_end_check("after_abort");

    // Random downloads with mixed index, gaps and occasional out-of-range bytes.
    for (int l = 0; l < 4; l++) begin
      dl_begin($urandom_range(1, 0));
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(9, 0) == 0) send($urandom_range(32'h1FFFFFF, 32'h40000), 8'($urandom));
        else                           send($urandom_range(32'h3FFFF, 0), 8'($urandom));
        idle($urandom_range(2, 0));
      end
      dl_end_check("random");
    end

    idle(3);
    check("final.pending_writes", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
